// File: rtl/sum_pkg.sv
// Shared definitions for the sum request initiator.
//   state_t       - initiator FSM state encoding
//   *_DEFAULT     - default sequence bounds and timeout
//   TIMER_W       - width of the WAIT-state cycle counter
//   expected_sum  - triangular number n*(n+1)/2, 5-bit unsigned
package sum_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StWait = 3'd2,
        StAck  = 3'd3,
        StNext = 3'd4,
        StDone = 3'd5
    } state_t;

    localparam int unsigned N_FIRST_DEFAULT = 1;
    localparam int unsigned N_LAST_DEFAULT  = 7;
    localparam int unsigned TIMEOUT_DEFAULT = 31;

    // Must be wide enough to hold TIMEOUT - 1.
    localparam int unsigned TIMER_W = 5;

    // Product is formed in 6 bits (max 7*8 = 56) so the halved result (max 28) fits 5 bits.
    function automatic logic [4:0] expected_sum(input logic [2:0] n);
        logic [5:0] prod;
        prod = {3'b000, n} * ({3'b000, n} + 6'd1);
        return prod[5:1];
    endfunction

endpackage

// File: rtl/sum_req_initiator_if.sv
// Request/response handshake between the sum initiator and its responder.
//   N, N_valid     - request operand and one-cycle request strobe (initiator -> responder)
//   sum, sum_valid - result and its valid flag (responder -> initiator)
//   ack            - result acknowledge (initiator -> responder)
interface sum_req_initiator_if;

    logic [2:0] N;
    logic       N_valid;
    logic [4:0] sum;
    logic       sum_valid;
    logic       ack;

    modport master (
        output N,
        output N_valid,
        output ack,
        input  sum,
        input  sum_valid
    );

    modport slave (
        input  N,
        input  N_valid,
        input  ack,
        output sum,
        output sum_valid
    );

endinterface

// File: rtl/wait_timer.sv
// Cycle counter for the WAIT state.
//   clk, reset - clock and synchronous active-high reset
//   clear      - force the count to zero (held while outside WAIT)
//   enable     - count up by one this cycle
//   tc         - terminal count: this is the Terminal-th enabled cycle since clear
module wait_timer #(
    parameter int unsigned Width    = 5,
    parameter int unsigned Terminal = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [Width-1:0] TermCount = Width'(Terminal - 1);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == TermCount);

endmodule

// File: rtl/sum_req_initiator.sv
// Issues requests N = N_FIRST..N_LAST to a responder, checks each returned sum
// against n*(n+1)/2 and counts mismatches and lost requests.
//   clk, reset - clock and synchronous active-high reset
//   start      - begin a sequence (honoured only in IDLE or DONE)
//   bus        - request/response handshake (master side)
//   busy       - sequence in progress
//   done       - sequence finished; outputs held until start or reset
//   err_count  - mismatches plus timeouts in this sequence, saturating at 7
//   last_sum   - most recently captured sum
module sum_req_initiator
    import sum_pkg::*;
#(
    parameter int unsigned N_FIRST = N_FIRST_DEFAULT,
    parameter int unsigned N_LAST  = N_LAST_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    sum_req_initiator_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             err_count,
    output logic [4:0]             last_sum
);

    localparam logic [2:0] NFirst = 3'(N_FIRST);
    localparam logic [2:0] NLast  = 3'(N_LAST);

    state_t     state_q, state_d;
    logic [2:0] n_q;
    logic [2:0] n_out_q;
    logic [2:0] err_q;
    logic [4:0] last_sum_q;
    logic       timer_clear;
    logic       timer_en;
    logic       timer_tc;

    wait_timer #(
        .Width    (TIMER_W),
        .Terminal (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StReq;
            StReq:   state_d = StWait;
            StWait: begin
                // A result arriving on the timeout cycle still counts as a response.
                if (bus.sum_valid)  state_d = StAck;
                else if (timer_tc)  state_d = StNext;
            end
            StAck:   if (!bus.sum_valid) state_d = StNext;
            StNext:  state_d = (n_q == NLast) ? StDone : StReq;
            StDone:  if (start) state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs.
    always_comb begin
        bus.N_valid = (state_q == StReq);
        bus.ack     = (state_q == StAck);
        busy        = !((state_q == StIdle) || (state_q == StDone));
        done        = (state_q == StDone);
        timer_en    = (state_q == StWait);
        timer_clear = (state_q != StWait);
    end

    // Datapath: operand, presented operand, error count, captured sum.
    // n_out_q is separate from n_q so N reads 0 out of reset while n_q holds N_FIRST.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q        <= NFirst;
            n_out_q    <= 3'd0;
            err_q      <= 3'd0;
            last_sum_q <= 5'd0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        n_q     <= NFirst;
                        n_out_q <= NFirst;
                        err_q   <= 3'd0;
                    end
                end
                StWait: begin
                    if (bus.sum_valid) begin
                        last_sum_q <= bus.sum;
                        if (bus.sum != expected_sum(n_q) && err_q != 3'd7) begin
                            err_q <= err_q + 3'd1;
                        end
                    end else if (timer_tc && err_q != 3'd7) begin
                        err_q <= err_q + 3'd1;
                    end
                end
                StNext: begin
                    if (n_q != NLast) begin
                        n_q     <= n_q + 3'd1;
                        n_out_q <= n_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.N     = n_out_q;
    assign err_count = err_q;
    assign last_sum  = last_sum_q;

endmodule
